// File: rtl/mgmt_tx_frame_padder_if.sv
// rtl/mgmt_tx_frame_padder_if.sv - EthernetTxBus word stream (start, data_valid, bytes_valid, data)
interface mgmt_tx_frame_padder_if;
    logic        start;
    logic        data_valid;
    logic [2:0]  bytes_valid;
    logic [31:0] data;

    modport master (output start, data_valid, bytes_valid, data);
    modport slave  (input  start, data_valid, bytes_valid, data);
endinterface

// File: rtl/mgmt_tx_frame_padder.sv
// rtl/mgmt_tx_frame_padder.sv - zero-pads short TX frames to MIN_BYTES through an elastic buffer
// Optional frame counters: define MGMT_TX_PAD_STATS_EN.
module mgmt_tx_frame_padder #(
    parameter int MIN_BYTES = 60,
    parameter int DEPTH     = 32
) (
    input  logic                   tx_clk,
    input  logic                   tx_rst_n,
    input  logic                   link_up,
    mgmt_tx_frame_padder_if.slave  in_bus,
    mgmt_tx_frame_padder_if.master out_bus,
    output logic                   overflow
`ifdef MGMT_TX_PAD_STATS_EN
    ,
    output logic [15:0]            frames_total,
    output logic [15:0]            frames_padded
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [10:0] MIN_CNT = 11'(MIN_BYTES);

    typedef enum logic [1:0] {K_START, K_DATA, K_END} kind_t;
    typedef struct packed {
        kind_t       kind;
        logic        end_prev;
        logic [2:0]  bv;
        logic [31:0] data;
    } entry_t;
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAD} state_t;

    entry_t      mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        in_dv_q;
    logic        full, empty, push_req, pop;
    entry_t      push_entry, head;
    state_t      state, state_nxt;
    logic [10:0] byte_cnt, cnt_nxt;
    logic [11:0] sum;
    logic [31:0] keep_mask;
    logic        o_start, o_dv;
    logic [2:0]  o_bv;
    logic [31:0] o_data;
    logic        out_start_q, out_dv_q;
    logic [2:0]  out_bv_q;
    logic [31:0] out_data_q;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];
    assign sum   = 12'(byte_cnt) + 12'(head.bv);

    // A start landing on the falling edge closes the previous frame itself via end_prev.
    always_comb begin
        push_req   = 1'b0;
        push_entry = '0;
        if (in_bus.start) begin
            push_req            = 1'b1;
            push_entry.kind     = K_START;
            push_entry.end_prev = in_dv_q && !in_bus.data_valid;
        end else if (in_bus.data_valid) begin
            push_req        = 1'b1;
            push_entry.kind = K_DATA;
            push_entry.bv   = in_bus.bytes_valid;
            push_entry.data = in_bus.data;
        end else if (in_dv_q) begin
            push_req        = 1'b1;
            push_entry.kind = K_END;
        end
    end

    always_comb begin
        case (head.bv)
            3'd1:    keep_mask = 32'hFF00_0000;
            3'd2:    keep_mask = 32'hFFFF_0000;
            3'd3:    keep_mask = 32'hFFFF_FF00;
            default: keep_mask = 32'hFFFF_FFFF;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = byte_cnt;
        pop       = 1'b0;
        o_start   = 1'b0;
        o_dv      = 1'b0;
        o_bv      = 3'd0;
        o_data    = 32'd0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head.kind == K_START) begin
                        o_start   = 1'b1;
                        cnt_nxt   = 11'd0;
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (!empty) begin
                    if (head.kind == K_DATA) begin
                        pop    = 1'b1;
                        o_dv   = 1'b1;
                        o_bv   = head.bv;
                        o_data = head.data;
                        cnt_nxt = sum[11] ? 11'h7FF : sum[10:0];
                        if (head.bv < 3'd4 && sum < 12'(MIN_BYTES)) begin
                            o_bv    = 3'd4;
                            o_data  = head.data & keep_mask;
                            cnt_nxt = byte_cnt + 11'd4;
                        end
                    end else if (head.kind == K_END || head.end_prev) begin
                        pop       = (head.kind == K_END);
                        state_nxt = (byte_cnt < MIN_CNT) ? S_PAD : S_IDLE;
                    end else begin
                        // Bare START: this frame's END was dropped, abandon its tail.
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_PAD: begin
                if (byte_cnt >= MIN_CNT) begin
                    state_nxt = S_IDLE;
                end else begin
                    o_dv    = 1'b1;
                    o_bv    = 3'd4;
                    cnt_nxt = byte_cnt + 11'd4;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (link_up && push_req && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            in_dv_q     <= 1'b0;
            overflow    <= 1'b0;
            state       <= S_IDLE;
            byte_cnt    <= 11'd0;
            out_start_q <= 1'b0;
            out_dv_q    <= 1'b0;
            out_bv_q    <= 3'd0;
            out_data_q  <= 32'd0;
        end else if (!link_up) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            in_dv_q     <= 1'b0;
            state       <= S_IDLE;
            byte_cnt    <= 11'd0;
            out_start_q <= 1'b0;
            out_dv_q    <= 1'b0;
            out_bv_q    <= 3'd0;
            out_data_q  <= 32'd0;
        end else begin
            in_dv_q <= in_bus.data_valid;
            if (push_req && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end else if (push_req) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            state       <= state_nxt;
            byte_cnt    <= cnt_nxt;
            out_start_q <= o_start;
            out_dv_q    <= o_dv;
            out_bv_q    <= o_bv;
            out_data_q  <= o_data;
        end
    end

    assign out_bus.start       = out_start_q;
    assign out_bus.data_valid  = out_dv_q;
    assign out_bus.bytes_valid = out_bv_q;
    assign out_bus.data        = out_data_q;

`ifdef MGMT_TX_PAD_STATS_EN
    logic padded_q;
    logic pad_evt;

    assign pad_evt = (state == S_DATA) && ((state_nxt == S_PAD) || (o_dv && (o_bv != head.bv)));

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            frames_total  <= 16'd0;
            frames_padded <= 16'd0;
            padded_q      <= 1'b0;
        end else if (link_up) begin
            if (o_start) begin
                frames_total <= frames_total + 16'd1;
                padded_q     <= 1'b0;
            end else if (pad_evt && !padded_q) begin
                frames_padded <= frames_padded + 16'd1;
                padded_q      <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mgmt_tx_frame_padder.sv
// tb/tb_mgmt_tx_frame_padder.sv - scoreboard bench for mgmt_tx_frame_padder
module tb_mgmt_tx_frame_padder;

    logic tx_clk = 1'b0;
    logic tx_rst_n;
    logic link_up;
    logic link_s;
    logic ovf_m, ovf_s;
    always #5 tx_clk = ~tx_clk;

    mgmt_tx_frame_padder_if in_m ();
    mgmt_tx_frame_padder_if out_m ();
    mgmt_tx_frame_padder_if in_s ();
    mgmt_tx_frame_padder_if out_s ();

`ifdef MGMT_TX_PAD_STATS_EN
    logic [15:0] total_m, padded_m, total_s, padded_s;
`endif

    mgmt_tx_frame_padder #(.MIN_BYTES(60), .DEPTH(32)) dut_m (
        .tx_clk(tx_clk), .tx_rst_n(tx_rst_n), .link_up(link_up),
        .in_bus(in_m), .out_bus(out_m), .overflow(ovf_m)
`ifdef MGMT_TX_PAD_STATS_EN
        , .frames_total(total_m), .frames_padded(padded_m)
`endif
    );

    mgmt_tx_frame_padder #(.MIN_BYTES(60), .DEPTH(4)) dut_s (
        .tx_clk(tx_clk), .tx_rst_n(tx_rst_n), .link_up(link_s),
        .in_bus(in_s), .out_bus(out_s), .overflow(ovf_s)
`ifdef MGMT_TX_PAD_STATS_EN
        , .frames_total(total_s), .frames_padded(padded_s)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_start_cyc = 0;
    logic [35:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] keep_mask(input logic [2:0] bv);
        case (bv)
            3'd1:    return 32'hFF00_0000;
            3'd2:    return 32'hFFFF_0000;
            3'd3:    return 32'hFFFF_FF00;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic drive(input bit sel, input logic s, input logic dv, input logic [2:0] bv, input logic [31:0] d);
        if (!sel) begin
            in_m.start = s; in_m.data_valid = dv; in_m.bytes_valid = bv; in_m.data = d;
        end else begin
            in_s.start = s; in_s.data_valid = dv; in_s.bytes_valid = bv; in_s.data = d;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge tx_clk);
            drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
            drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
        end
    endtask

    // Frame is closed by whatever the caller drives next (idle or another start).
    task automatic send_frame(input bit sel, input int nbytes, input logic [31:0] base, input int drop_at);
        int nw, cnt, keep;
        logic [31:0] d, ed;
        logic [2:0]  bv, ebv;
        nw   = (nbytes + 3) / 4;
        keep = (drop_at >= 0) ? drop_at - 1 : nw;
        @(negedge tx_clk);
        drive(sel, 1'b1, 1'b0, 3'd0, 32'd0);
        start_cyc = cyc;
        if (!sel) exp_q.push_back({1'b1, 35'd0});
        cnt = 0;
        for (int i = 0; i < nw; i++) begin
            bv  = (i == nw - 1 && nbytes % 4 != 0) ? 3'(nbytes % 4) : 3'd4;
            d   = base + 32'(i) * 32'h0101_0101;
            ebv = bv;
            ed  = d;
            if (bv != 3'd4 && cnt + int'(bv) < 60) begin
                ebv = 3'd4;
                ed  = d & keep_mask(bv);
            end
            cnt += int'(ebv);
            if (!sel && i < keep) exp_q.push_back({1'b0, ebv, ed});
            @(negedge tx_clk);
            if (drop_at >= 0 && i == drop_at + 1) chk("link_drop_dv", 64'(out_m.data_valid), 64'd0);
            if (i == drop_at) link_up = 1'b0;
            drive(sel, 1'b0, 1'b1, bv, d);
        end
        if (!sel && drop_at < 0) begin
            while (cnt < 60) begin
                exp_q.push_back({1'b0, 3'd4, 32'd0});
                cnt += 4;
            end
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        idle(1);
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge tx_clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain actual=%0d left required=0", name, exp_q.size());
            exp_q.delete();
        end
        idle(2);
    endtask

    initial forever begin
        @(posedge tx_clk);
        cyc++;
    end

    initial begin : monitor
        logic prev_dv;
        logic [35:0] e;
        prev_dv = 1'b0;
        forever begin
            @(negedge tx_clk);
            if (tx_rst_n) begin
                if (out_m.start) begin
                    last_start_cyc = cyc;
                    chk("idle_before_start", 64'(prev_dv), 64'd0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start actual=start required=nothing");
                    end else begin
                        e = exp_q.pop_front();
                        chk("start_order", 64'(e[35]), 64'd1);
                    end
                end
                if (out_m.data_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word actual=%0h required=nothing", out_m.data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_order", 64'(e[35]), 64'd0);
                        chk("bytes_valid", 64'(out_m.bytes_valid), 64'(e[34:32]));
                        chk("data", 64'(out_m.data), 64'(e[31:0]));
                    end
                end
                prev_dv = out_m.data_valid;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : stim
        bit active;
        tx_rst_n = 1'b0;
        link_up  = 1'b1;
        link_s   = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
        idle(3);
        tx_rst_n = 1'b1;
        idle(1);
        chk("reset_start", 64'(out_m.start), 64'd0);
        chk("reset_dv", 64'(out_m.data_valid), 64'd0);
        chk("reset_bv", 64'(out_m.bytes_valid), 64'd0);
        chk("reset_data", 64'(out_m.data), 64'd0);
        chk("reset_overflow", 64'(ovf_m), 64'd0);
        chk("reset_overflow_small", 64'(ovf_s), 64'd0);

        send_frame(1'b0, 64, 32'h1020_3040, -1);
        drain("f64");
        chk("start_latency", 64'(last_start_cyc - start_cyc), 64'd2);
        chk("overflow_f64", 64'(ovf_m), 64'd0);

        send_frame(1'b0, 14, 32'hAABB_CCDD, -1);
        drain("f14");
        send_frame(1'b0, 60, 32'h0102_0304, -1);
        drain("f60");
        send_frame(1'b0, 61, 32'h5566_7788, -1);
        drain("f61");

        send_frame(1'b0, 20, 32'h2200_0011, -1);
        idle(3);
        send_frame(1'b0, 20, 32'h3300_0022, -1);
        drain("b2b20");
        chk("overflow_b2b", 64'(ovf_m), 64'd0);

        send_frame(1'b0, 64, 32'h4000_0001, 7);
        idle(3);
        link_up = 1'b1;
        idle(3);
        send_frame(1'b0, 64, 32'h5000_0002, -1);
        drain("after_link");
        chk("overflow_main_end", 64'(ovf_m), 64'd0);

        send_frame(1'b1, 24, 32'h6000_0003, -1);
        send_frame(1'b1, 8, 32'h7000_0004, -1);
        send_frame(1'b1, 8, 32'h7100_0005, -1);
        send_frame(1'b1, 8, 32'h7200_0006, -1);
        idle(1);
        chk("overflow_small_set", 64'(ovf_s), 64'd1);
        link_s = 1'b0;
        idle(2);
        link_s = 1'b1;
        active = 1'b0;
        repeat (30) begin
            idle(1);
            if (out_s.start || out_s.data_valid) active = 1'b1;
        end
        chk("flush_no_output", 64'(active), 64'd0);
        chk("overflow_small_sticky", 64'(ovf_s), 64'd1);

`ifdef MGMT_TX_PAD_STATS_EN
        chk("frames_total", 64'(total_m), 64'd8);
        chk("frames_padded", 64'(padded_m), 64'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
